// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 keyboard receiver that keeps the HID code of the held movement/space key.
// Frames are taken on PS/2 falling edges; a stalled partial frame is abandoned after TIMEOUT_CYCLES.
module ps2_keycode_source #(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CNT_W          = 14
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic [7:0] scan_byte,
   output logic       scan_strobe,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]       r_clkSync;
   logic [1:0]       r_dataSync;
   logic             r_prevClk;
   state_t           r_state;
   logic [2:0]       r_bitCnt;
   logic [7:0]       r_shreg;
   logic             r_parity;
   logic [CNT_W-1:0] r_toCnt;
   logic             r_breakFlag;
   logic             r_extFlag;

   logic             w_fall;
   logic             w_data;
   logic             w_good;
   logic             w_timeout;
   logic             w_mapValid;
   logic [7:0]       w_mapCode;

   // Sync flops preset high so the idle-high bus never looks like a falling edge out of reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
         r_prevClk  <= 1'b1;
      end else begin
         r_clkSync  <= {r_clkSync[0], ps2_clk};
         r_dataSync <= {r_dataSync[0], ps2_data};
         r_prevClk  <= r_clkSync[1];
      end
   end

   assign w_fall    = r_prevClk & ~r_clkSync[1];
   assign w_data    = r_dataSync[1];
   assign w_good    = w_data & (^{r_shreg, r_parity});
   assign w_timeout = (r_toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_mapValid = 1'b1;
      w_mapCode  = 8'h00;
      case (r_shreg)
         8'h1C:   w_mapCode = 8'h04;
         8'h23:   w_mapCode = 8'h07;
         8'h1B:   w_mapCode = 8'h16;
         8'h1D:   w_mapCode = 8'h1A;
         8'h29:   w_mapCode = 8'h2C;
         default: w_mapValid = 1'b0;
      endcase
   end

   // Receiver, timeout and make/break decoder; a falling edge takes priority over timeout expiry
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_bitCnt    <= 3'd0;
         r_shreg     <= 8'h00;
         r_parity    <= 1'b0;
         r_toCnt     <= '0;
         r_breakFlag <= 1'b0;
         r_extFlag   <= 1'b0;
         keycode     <= 8'h00;
         scan_byte   <= 8'h00;
         scan_strobe <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         scan_strobe <= 1'b0;
         frame_err   <= 1'b0;
         if (w_fall) begin
            r_toCnt <= '0;
            case (r_state)
               IDLE: begin
                  if (!w_data) begin
                     r_state  <= DATA;
                     r_bitCnt <= 3'd0;
                  end
               end
               DATA: begin
                  r_shreg[r_bitCnt] <= w_data;
                  r_bitCnt          <= r_bitCnt + 3'd1;
                  if (r_bitCnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
                  r_parity <= w_data;
                  r_state  <= STOP;
               end
               STOP: begin
                  r_state <= IDLE;
                  if (w_good) begin
                     scan_byte   <= r_shreg;
                     scan_strobe <= 1'b1;
                     if (r_shreg == 8'hF0) begin
                        r_breakFlag <= 1'b1;
                     end else if (r_shreg == 8'hE0) begin
                        r_extFlag <= 1'b1;
                     end else begin
                        // Extended codes never map, so an E0 F0 xx sequence is ignored entirely
                        if (!r_extFlag && w_mapValid) begin
                           if (!r_breakFlag)
                              keycode <= w_mapCode;
                           else if (keycode == w_mapCode)
                              keycode <= 8'h00;
                        end
                        r_breakFlag <= 1'b0;
                        r_extFlag   <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end else if (r_state != IDLE) begin
            if (w_timeout) begin
               r_state   <= IDLE;
               r_toCnt   <= '0;
               frame_err <= 1'b1;
            end else begin
               r_toCnt <= r_toCnt + CNT_W'(1);
            end
         end else begin
            r_toCnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Scoreboard bench for ps2_keycode_source: stimulus pushes expected strobes/errors from a
// key-state model, and a monitor pops and compares whenever the DUT reports a byte or error.
module tb_ps2_keycode_source;

   localparam int TIMEOUT = 10000;
   localparam int HALF    = 8;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keycode;
   logic [7:0] scan_byte;
   logic       scan_strobe;
   logic       frame_err;

   ps2_keycode_source #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(14)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .keycode     (keycode),
      .scan_byte   (scan_byte),
      .scan_strobe (scan_strobe),
      .frame_err   (frame_err)
   );

   always #10 Clk = ~Clk;

   typedef struct {
      bit         isErr;
      logic [7:0] b;
      logic [7:0] key;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model: keyboard state as "held key" plus the prefixes seen since the last code
   logic [7:0] keyMap[logic [7:0]];
   logic [7:0] modelKey = 8'h00;
   bit         sawBreak = 0;
   bit         sawExt = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelByte(input logic [7:0] b);
      if (b == 8'hF0) sawBreak = 1;
      else if (b == 8'hE0) sawExt = 1;
      else begin
         if (!sawExt && keyMap.exists(b)) begin
            if (!sawBreak) modelKey = keyMap[b];
            else if (modelKey == keyMap[b]) modelKey = 8'h00;
         end
         sawBreak = 0;
         sawExt   = 0;
      end
   endtask

   task automatic sendBit(input logic v);
      ps2_data = v;
      repeat (HALF) @(negedge Clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge Clk);
      ps2_clk = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input bit badParity, input int nBits);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ badParity, b, 1'b0};
      for (int i = 0; i < nBits; i++) sendBit(bits[i]);
      ps2_data = 1'b1;
      repeat (2 * HALF) @(negedge Clk);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit badParity);
      exp_t e;
      if (badParity) begin
         e = '{isErr: 1, b: 8'h00, key: 8'h00};
      end else begin
         modelByte(b);
         e = '{isErr: 0, b: b, key: modelKey};
      end
      expQ.push_back(e);
      sendFrame(b, badParity, 11);
   endtask

   // Monitor: every strobe or error must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!Reset && (scan_strobe || frame_err)) begin
            if (scan_strobe && frame_err) checkOutput("strobeAndErrTogether", 1, 0);
            if (expQ.size() == 0) begin
               checkOutput("unexpectedEvent", {scan_strobe, frame_err}, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("frameErr", frame_err, e.isErr);
               if (!e.isErr) begin
                  checkOutput("scanByte", scan_byte, e.b);
                  checkOutput("keycode", keycode, e.key);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] pool [9];
      logic [7:0] b;
      int         idx;
      keyMap[8'h1C] = 8'h04;
      keyMap[8'h23] = 8'h07;
      keyMap[8'h1B] = 8'h16;
      keyMap[8'h1D] = 8'h1A;
      keyMap[8'h29] = 8'h2C;
      pool = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'hF0, 8'hE0, 8'h15, 8'h00};

      repeat (4) @(negedge Clk);
      checkOutput("resetKeycode", keycode, 0);
      checkOutput("resetScanByte", scan_byte, 0);
      checkOutput("resetStrobe", scan_strobe, 0);
      checkOutput("resetErr", frame_err, 0);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      // Press and release A
      applyStimulus(8'h1C, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      // Last key wins; stale break of A is ignored
      applyStimulus(8'h1C, 0);
      applyStimulus(8'h23, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h23, 0);
      // W held across extended and unmapped codes
      applyStimulus(8'h1D, 0);
      applyStimulus(8'hE0, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'h15, 0);
      applyStimulus(8'hE0, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'h1D, 0);
      // Parity error then a valid frame
      applyStimulus(8'h1D, 1);
      applyStimulus(8'h1D, 0);

      // Timeout on a partial frame (start + 3 data bits)
      expQ.push_back('{isErr: 1, b: 8'h00, key: 8'h00});
      sendFrame(8'h29, 0, 4);
      repeat (TIMEOUT + 50) @(negedge Clk);
      checkOutput("timeoutDrained", expQ.size(), 0);
      applyStimulus(8'h29, 0);

      // Reset mid-frame with A held
      applyStimulus(8'h1C, 0);
      sendFrame(8'h1B, 0, 6);
      Reset = 1'b1;
      #1;
      checkOutput("midResetKeycode", keycode, 0);
      checkOutput("midResetScanByte", scan_byte, 0);
      checkOutput("midResetStrobe", scan_strobe, 0);
      checkOutput("midResetErr", frame_err, 0);
      modelKey = 8'h00;
      sawBreak = 0;
      sawExt   = 0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      applyStimulus(8'h1B, 0);

      // Randomized key traffic with occasional parity corruption
      for (int n = 0; n < 80; n++) begin
         idx = $urandom_range(0, 8);
         b = (idx == 8) ? 8'($urandom) : pool[idx];
         applyStimulus(b, $urandom_range(0, 9) == 0);
      end

      for (int i = 0; i < 500 && expQ.size() != 0; i++) @(negedge Clk);
      checkOutput("queueDrained", expQ.size(), 0);
      checkOutput("finalKeycode", keycode, modelKey);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
